// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the round-robin shared sequence detector.
// Contents: MAX_PAT_W / FILL_W sizing constants, default pattern, history and
// fill typedefs sized for the largest supported pattern, ch_idx_w() index-width helper.
package seq_det_pkg;

  localparam int unsigned MAX_PAT_W = 8;
  localparam int unsigned FILL_W    = 3;
  localparam logic [3:0]  DEF_PATTERN = 4'b1001;

  // History holds the last MAX_PAT_W-1 bits; unused upper bits stay zero.
  typedef logic [MAX_PAT_W-2:0] hist_t;
  typedef logic [FILL_W-1:0]    fill_t;

  function automatic int unsigned ch_idx_w(input int unsigned n);
    if (n < 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer (wrapping); pointer moves past the granted channel.
// Ports: clk, reset (sync, active-high), i_req[NUM_CH], o_gnt[NUM_CH] (combinational,
// forced to zero during reset), o_gnt_idx (binary index of the grant).
module rr_arbiter
  import seq_det_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  localparam int unsigned IDX_W  = ch_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] i_req,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [IDX_W-1:0]  o_gnt_idx
);

  logic [IDX_W-1:0]  r_ptr;
  logic [NUM_CH-1:0] w_gnt;
  logic [IDX_W-1:0]  w_idx;
  logic [IDX_W-1:0]  w_cand;
  logic              w_found;

  // Scan from the pointer, first requester wins.
  always_comb begin
    w_gnt   = '0;
    w_idx   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      w_cand = IDX_W'((32'(r_ptr) + k) % NUM_CH);
      if (!w_found && i_req[w_cand]) begin
        w_found       = 1'b1;
        w_gnt[w_cand] = 1'b1;
        w_idx         = w_cand;
      end
    end
  end

  assign o_gnt     = reset ? '0 : w_gnt;
  assign o_gnt_idx = w_idx;

  // Pointer advances only when a grant is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (|o_gnt) begin
      r_ptr <= (32'(w_idx) == NUM_CH - 1) ? '0 : w_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_rr_sched.sv
// Shares one serial pattern detector among NUM_CH bit-serial channels. A
// round-robin arbiter grants one channel per cycle; that channel's stored
// history is combined with its new bit and compared against PATTERN.
// Ports: clk, reset (sync, active-high), ch_valid/ch_bit/ch_flush[NUM_CH] in,
// ch_ready[NUM_CH] out (combinational one-hot grant), cfg_overlap in,
// match_valid/match_ch out (registered, one cycle after the accepting edge).
// Optional: define MATCH_COUNT_EN to add per-channel 8-bit saturating match
// counters read through cnt_sel (in) / cnt_value (out, combinational).
module seq_detect_rr_sched
  import seq_det_pkg::*;
#(
  parameter  int unsigned      NUM_CH  = 4,
  parameter  int unsigned      PAT_W   = 4,
  parameter  logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  localparam int unsigned      IDX_W   = ch_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_valid,
  input  logic [NUM_CH-1:0] ch_bit,
  input  logic [NUM_CH-1:0] ch_flush,
  output logic [NUM_CH-1:0] ch_ready,
  input  logic              cfg_overlap,
  output logic              match_valid,
  output logic [IDX_W-1:0]  match_ch
`ifdef MATCH_COUNT_EN
  ,
  input  logic [IDX_W-1:0]  cnt_sel,
  output logic [7:0]        cnt_value
`endif
);

  localparam logic [MAX_PAT_W-1:0] WIN_MASK  = MAX_PAT_W'((32'd1 << PAT_W) - 32'd1);
  localparam logic [MAX_PAT_W-2:0] HIST_MASK = (MAX_PAT_W-1)'((32'd1 << (PAT_W - 1)) - 32'd1);
  localparam logic [MAX_PAT_W-1:0] PAT_EXT   = MAX_PAT_W'(PATTERN);
  localparam fill_t                FILL_MAX  = FILL_W'(PAT_W - 1);

  hist_t             r_hist [NUM_CH];
  fill_t             r_fill [NUM_CH];
  logic              r_match_valid;
  logic [IDX_W-1:0]  r_match_ch;

  logic [NUM_CH-1:0]    w_elig;
  logic [NUM_CH-1:0]    w_gnt;
  logic [IDX_W-1:0]     w_gidx;
  logic [MAX_PAT_W-1:0] w_win;
  logic                 w_hit;
  logic                 w_clr;
  hist_t                w_hist_nxt;
  fill_t                w_fill_nxt;

  // A channel being flushed is not eligible for a grant in the same cycle.
  assign w_elig = ch_valid & ~ch_flush;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_req     (w_elig),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gidx)
  );

  assign ch_ready = w_gnt;

  // Shared detector datapath for the granted channel.
  always_comb begin
    w_win      = {r_hist[w_gidx], ch_bit[w_gidx]};
    w_hit      = (|w_gnt) && ((w_win & WIN_MASK) == PAT_EXT) && (r_fill[w_gidx] == FILL_MAX);
    w_clr      = w_hit && !cfg_overlap;
    w_hist_nxt = w_clr ? '0 : (w_win[MAX_PAT_W-2:0] & HIST_MASK);
    w_fill_nxt = '0;
    if (!w_clr) begin
      w_fill_nxt = (r_fill[w_gidx] == FILL_MAX) ? FILL_MAX : r_fill[w_gidx] + FILL_W'(1);
    end
  end

  // Per-channel history update and registered match report.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_hist[i] <= '0;
        r_fill[i] <= '0;
      end
      r_match_valid <= 1'b0;
      r_match_ch    <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (ch_flush[i]) begin
          r_hist[i] <= '0;
          r_fill[i] <= '0;
        end else if (w_gnt[i]) begin
          r_hist[i] <= w_hist_nxt;
          r_fill[i] <= w_fill_nxt;
        end
      end
      r_match_valid <= w_hit;
      if (w_hit) begin
        r_match_ch <= w_gidx;
      end
    end
  end

  assign match_valid = r_match_valid;
  assign match_ch    = r_match_ch;

`ifdef MATCH_COUNT_EN
  logic [7:0] r_cnt [NUM_CH];

  // Saturating per-channel match counters; flush does not clear them.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (w_hit && (r_cnt[w_gidx] != 8'hFF)) begin
      r_cnt[w_gidx] <= r_cnt[w_gidx] + 8'd1;
    end
  end

  assign cnt_value = r_cnt[cnt_sel];
`endif

endmodule

// File: tb/tb_seq_detect_rr_sched.sv
// Self-checking bench for seq_detect_rr_sched (default parameters).
// Stimulus pushes expected matches into a scoreboard queue; a negedge monitor
// pops and checks channel and latency, and checks match_ch holds otherwise.
// Counter checks run only when MATCH_COUNT_EN is defined.
module tb_seq_detect_rr_sched;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned IDX_W  = 2;

  logic              clk;
  logic              reset;
  logic [NUM_CH-1:0] ch_valid;
  logic [NUM_CH-1:0] ch_bit;
  logic [NUM_CH-1:0] ch_flush;
  logic [NUM_CH-1:0] ch_ready;
  logic              cfg_overlap;
  logic              match_valid;
  logic [IDX_W-1:0]  match_ch;
`ifdef MATCH_COUNT_EN
  logic [IDX_W-1:0]  cnt_sel;
  logic [7:0]        cnt_value;
`endif

  seq_detect_rr_sched dut (
    .clk         (clk),
    .reset       (reset),
    .ch_valid    (ch_valid),
    .ch_bit      (ch_bit),
    .ch_flush    (ch_flush),
    .ch_ready    (ch_ready),
    .cfg_overlap (cfg_overlap),
    .match_valid (match_valid),
    .match_ch    (match_ch)
`ifdef MATCH_COUNT_EN
    ,
    .cnt_sel     (cnt_sel),
    .cnt_value   (cnt_value)
`endif
  );

  typedef struct {
    int ch;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_ch = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare each reported match against the scoreboard head.
  always @(negedge clk) begin
    if (reset) begin
      last_ch = 0;
    end else if (match_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_match", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("match_ch", int'(match_ch), e.ch);
        chk("match_latency", cyc, e.cyc);
        last_ch = e.ch;
      end
    end else begin
      chk("match_ch_hold", int'(match_ch), last_ch);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Present one bit on a channel until granted; record an expected match.
  task automatic send(input int ch, input bit b, input bit exp_hit);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    ch_valid[ch] = 1'b1;
    ch_bit[ch]   = b;
    #1;
    while (!ch_ready[ch] && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!ch_ready[ch]) begin
      chk("grant_timeout", 0, 1);
    end else if (exp_hit) begin
      e.ch  = ch;
      e.cyc = cyc + 1;
      sb_q.push_back(e);
    end
    @(negedge clk);
    ch_valid[ch] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    ch_valid = '1;
    ch_flush = '0;
    #1;
    chk("ready_in_reset", int'(ch_ready), 0);
    @(negedge clk);
    @(negedge clk);
    reset    = 1'b0;
    ch_valid = '0;
    #1;
    chk("rst_match_valid", int'(match_valid), 0);
    chk("rst_match_ch", int'(match_ch), 0);
  endtask

  initial begin
    bit t1b [7] = '{1, 0, 0, 1, 0, 0, 1};
    bit t1e [7] = '{0, 0, 0, 1, 0, 0, 0};
    bit t2e [7] = '{0, 0, 0, 1, 0, 0, 1};
    int rr_all [6] = '{1, 2, 4, 8, 1, 2};
    int rr_odd [4] = '{8, 2, 8, 2};
    bit p4b [4] = '{1, 0, 0, 1};

    reset       = 1'b1;
    ch_valid    = '0;
    ch_bit      = '0;
    ch_flush    = '0;
    cfg_overlap = 1'b0;
`ifdef MATCH_COUNT_EN
    cnt_sel     = '0;
`endif
    repeat (2) @(negedge clk);

    // T1: non-overlapping, single match
    do_reset();
    cfg_overlap = 1'b0;
    for (int i = 0; i < 7; i++) send(0, t1b[i], t1e[i]);

    // T2: overlapping, shared middle bit yields second match
    do_reset();
    cfg_overlap = 1'b1;
    for (int i = 0; i < 7; i++) send(0, t1b[i], t2e[i]);

    // T3: round-robin rotation
    do_reset();
    @(negedge clk);
    ch_valid = '1;
    ch_bit   = '0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_all", int'(ch_ready), rr_all[i]);
      @(negedge clk);
    end
    ch_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_odd", int'(ch_ready), rr_odd[i]);
      @(negedge clk);
    end
    ch_valid = '0;

    // T4: interleaved channels keep separate histories
    do_reset();
    cfg_overlap = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(0, p4b[i], (i == 3));
      send(2, p4b[i], (i == 3));
    end

    // T5: reset discards a partial pattern
    do_reset();
    send(1, 1'b1, 1'b0);
    send(1, 1'b0, 1'b0);
    send(1, 1'b0, 1'b0);
    do_reset();
    send(1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send(1, p4b[i], (i == 3));

    // T6: flush blocks grant and clears history
    do_reset();
    send(0, 1'b1, 1'b0);
    send(0, 1'b0, 1'b0);
    send(0, 1'b0, 1'b0);
    @(negedge clk);
    ch_valid = 4'b0011;
    ch_flush = 4'b0001;
    ch_bit   = '0;
    #1;
    chk("flush_ready", int'(ch_ready), 2);
    @(negedge clk);
    ch_valid = '0;
    ch_flush = '0;
    for (int i = 0; i < 4; i++) send(0, p4b[i], (i == 3));

`ifdef MATCH_COUNT_EN
    // T7: counter saturation on ch3, others untouched
    do_reset();
    cfg_overlap = 1'b1;
    for (int i = 0; i < 4; i++) send(3, p4b[i], (i == 3));
    for (int m = 1; m < 300; m++) begin
      send(3, 1'b0, 1'b0);
      send(3, 1'b0, 1'b0);
      send(3, 1'b1, 1'b1);
    end
    repeat (3) @(negedge clk);
    cnt_sel = 2'd3;
    #1;
    chk("cnt_ch3", int'(cnt_value), 255);
    for (int c = 0; c < 3; c++) begin
      cnt_sel = IDX_W'(c);
      #1;
      chk("cnt_other", int'(cnt_value), 0);
    end
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_drain", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
